// File: rtl/io_port_bridge.sv
// Peripheral bridge for the processor's in/out instructions: an output FIFO drained
// onto a transmit channel and an input FIFO filled from a receive channel.
module io_port_bridge #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_out_we,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_in_re,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic [DATA_W-1:0] ext_tx_data,
    output logic              ext_tx_valid,
    input  logic              ext_tx_ready,
    input  logic [DATA_W-1:0] ext_rx_data,
    input  logic              ext_rx_valid,
    output logic              ext_rx_ready,
    input  logic              clr_flags,
    output logic              out_full,
    output logic              out_overflow,
    output logic              in_empty,
    output logic              in_underflow
);

    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam logic [OAW:0] OUT_MAX = (OAW + 1)'(OUT_DEPTH);
    localparam logic [IAW:0] IN_MAX  = (IAW + 1)'(IN_DEPTH);

    // Handshake: a word moves across a channel on a rising edge where valid and ready
    // are both 1; the holder keeps valid and data stable until that edge.

    logic [DATA_W-1:0] out_mem [OUT_DEPTH];
    logic [OAW-1:0]    out_rd, out_wr;
    logic [OAW:0]      out_cnt;
    logic              out_push, out_pop, out_ovf_evt;

    logic [DATA_W-1:0] in_mem [IN_DEPTH];
    logic [IAW-1:0]    in_rd, in_wr;
    logic [IAW:0]      in_cnt;
    logic              in_push, in_pop, in_unf_evt;

    // All outputs below depend only on registered state.
    assign out_full     = (out_cnt == OUT_MAX);
    assign ext_tx_valid = (out_cnt != '0);
    assign ext_tx_data  = out_mem[out_rd];

    assign in_empty     = (in_cnt == '0);
    assign ext_rx_ready = (in_cnt != IN_MAX);
    assign cpu_in_data  = in_empty ? '0 : in_mem[in_rd];

    assign out_pop     = ext_tx_valid & ext_tx_ready;
    assign out_push    = cpu_out_we & (~out_full | out_pop);
    assign out_ovf_evt = cpu_out_we & out_full & ~out_pop;

    assign in_push    = ext_rx_valid & ext_rx_ready;
    assign in_pop     = cpu_in_re & ~in_empty;
    assign in_unf_evt = cpu_in_re & in_empty;

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wr] <= cpu_out_data;
        if (in_push)  in_mem[in_wr]   <= ext_rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_rd  <= '0;
            out_wr  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_rd  <= '0;
            in_wr  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + 1'b1;
            if (in_pop)  in_rd <= in_rd + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // A fresh event outranks a clear arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_overflow <= 1'b0;
            in_underflow <= 1'b0;
        end else begin
            if (out_ovf_evt)    out_overflow <= 1'b1;
            else if (clr_flags) out_overflow <= 1'b0;
            if (in_unf_evt)     in_underflow <= 1'b1;
            else if (clr_flags) in_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed scenarios plus a random stream, with queues
// holding the words expected on each side.
module tb_io_port_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_out_we = 1'b0;
    logic [15:0] cpu_out_data = 16'h0;
    logic        cpu_in_re = 1'b0;
    logic [15:0] cpu_in_data;
    logic [15:0] ext_tx_data;
    logic        ext_tx_valid;
    logic        ext_tx_ready = 1'b0;
    logic [15:0] ext_rx_data = 16'h0;
    logic        ext_rx_valid = 1'b0;
    logic        ext_rx_ready;
    logic        clr_flags = 1'b0;
    logic        out_full, out_overflow, in_empty, in_underflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] in_q[$];

    io_port_bridge #(.DATA_W(16), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_out_we(cpu_out_we), .cpu_out_data(cpu_out_data),
        .cpu_in_re(cpu_in_re), .cpu_in_data(cpu_in_data),
        .ext_tx_data(ext_tx_data), .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready),
        .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid), .ext_rx_ready(ext_rx_ready),
        .clr_flags(clr_flags), .out_full(out_full), .out_overflow(out_overflow),
        .in_empty(in_empty), .in_underflow(in_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Inputs change at the falling edge; outputs are sampled right after.
    task automatic drive(input logic we, input logic [15:0] od, input logic txr,
                         input logic rxv, input logic [15:0] rxd, input logic re,
                         input logic clr);
        @(negedge clk);
        cpu_out_we   = we;
        cpu_out_data = od;
        ext_tx_ready = txr;
        ext_rx_valid = rxv;
        ext_rx_data  = rxd;
        cpu_in_re    = re;
        clr_flags    = clr;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ext_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", ext_tx_valid); end
        checks++; if (ext_rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready: got %b expected 1", ext_rx_ready); end
        checks++; if (in_empty !== 1'b1) begin errors++; $display("FAIL rst_in_empty: got %b expected 1", in_empty); end
        checks++; if (out_full !== 1'b0) begin errors++; $display("FAIL rst_out_full: got %b expected 0", out_full); end
        checks++; if (cpu_in_data !== 16'h0) begin errors++; $display("FAIL rst_in_data: got %h expected 0000", cpu_in_data); end
        checks++; if ({out_overflow, in_underflow} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {out_overflow, in_underflow}); end
        reset = 1'b0;
    endtask

    task automatic test_out_basic();
        logic [15:0] e;
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        exp_q.push_back(16'h1234);
        checks++; if (ext_tx_valid !== 1'b0) begin errors++; $display("FAIL ob_valid0: got %b expected 0", ext_tx_valid); end
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        exp_q.push_back(16'hBEEF);
        e = exp_q.pop_front();
        checks++; if (ext_tx_valid !== 1'b1 || ext_tx_data !== e) begin errors++; $display("FAIL ob_word1: got v=%b %h expected v=1 %h", ext_tx_valid, ext_tx_data, e); end
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++; if (ext_tx_valid !== 1'b1 || ext_tx_data !== e) begin errors++; $display("FAIL ob_word2: got v=%b %h expected v=1 %h", ext_tx_valid, ext_tx_data, e); end
        idle();
        checks++; if (ext_tx_valid !== 1'b0) begin errors++; $display("FAIL ob_drained: got %b expected 0", ext_tx_valid); end
    endtask

    task automatic test_out_overflow();
        logic [15:0] e;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            if (i <= 4) exp_q.push_back(16'(i));
            if (i == 5) begin
                checks++; if (out_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", out_full); end
            end
        end
        idle();
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", out_overflow); end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            if (ext_tx_valid) begin
                e = exp_q.pop_front();
                checks++; if (ext_tx_data !== e) begin errors++; $display("FAIL ovf_drain: got %h expected %h", ext_tx_data, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain_count: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        idle();
        checks++; if (out_overflow !== 1'b0 || ext_tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_clear: got ovf=%b v=%b expected 0 0", out_overflow, ext_tx_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            exp_q.push_back(16'h0010 + 16'(i));
        end
        drive(1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++; if (out_full !== 1'b1) begin errors++; $display("FAIL fpp_full_before: got %b expected 1", out_full); end
        e = exp_q.pop_front();
        checks++; if (ext_tx_data !== e) begin errors++; $display("FAIL fpp_head: got %h expected %h", ext_tx_data, e); end
        exp_q.push_back(16'h00AA);
        idle();
        checks++; if (out_full !== 1'b1 || out_overflow !== 1'b0) begin errors++; $display("FAIL fpp_after: got full=%b ovf=%b expected 1 0", out_full, out_overflow); end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            if (ext_tx_valid) begin
                e = exp_q.pop_front();
                checks++; if (ext_tx_data !== e) begin errors++; $display("FAIL fpp_drain: got %h expected %h", ext_tx_data, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fpp_drain_count: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
        idle();
    endtask

    task automatic test_in_basic();
        logic [15:0] e;
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
        in_q.push_back(16'h0007);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFF0, 1'b0, 1'b0);
        in_q.push_back(16'hFFF0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        e = in_q.pop_front();
        checks++; if (in_empty !== 1'b0 || cpu_in_data !== e) begin errors++; $display("FAIL in_word1: got empty=%b %h expected 0 %h", in_empty, cpu_in_data, e); end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        e = in_q.pop_front();
        checks++; if (cpu_in_data !== e) begin errors++; $display("FAIL in_word2: got %h expected %h", cpu_in_data, e); end
        idle();
        checks++; if (in_empty !== 1'b1 || in_underflow !== 1'b0 || cpu_in_data !== 16'h0) begin errors++; $display("FAIL in_after: got empty=%b unf=%b data=%h expected 1 0 0000", in_empty, in_underflow, cpu_in_data); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0);
        checks++; if (cpu_in_data !== 16'h0) begin errors++; $display("FAIL unf_data: got %h expected 0000", cpu_in_data); end
        in_q.push_back(16'h0042);
        idle();
        checks++; if (in_underflow !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b expected 1", in_underflow); end
        checks++; if (in_empty !== 1'b0 || cpu_in_data !== in_q[0]) begin errors++; $display("FAIL unf_head: got empty=%b %h expected 0 %h", in_empty, cpu_in_data, in_q[0]); end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        idle();
        checks++; if (in_underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", in_underflow); end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        void'(in_q.pop_front());
        // Underflow on the same edge as a clear leaves the flag set.
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        idle();
        checks++; if (in_underflow !== 1'b1) begin errors++; $display("FAIL unf_vs_clr: got %b expected 1", in_underflow); end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_random();
        logic we, txr, rxv, re, clr, opop, ovf_evt, unf_evt;
        logic exp_ovf = 1'b0;
        logic exp_unf = 1'b0;
        logic [15:0] od, rxd, e, ein;
        int osz, isz;
        for (int i = 0; i < 400; i++) begin
            we  = 1'($urandom_range(0, 1));
            txr = 1'($urandom_range(0, 2) != 0);
            rxv = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 2) == 0);
            clr = 1'($urandom_range(0, 15) == 0);
            od  = 16'($urandom_range(0, 65535));
            rxd = 16'($urandom_range(0, 65535));
            drive(we, od, txr, rxv, rxd, re, clr);
            osz = exp_q.size();
            isz = in_q.size();
            checks++; if (ext_tx_valid !== (osz > 0) || out_full !== (osz == 4)) begin errors++; $display("FAIL rnd_out_status: got v=%b full=%b expected count %0d", ext_tx_valid, out_full, osz); end
            checks++; if (ext_rx_ready !== (isz < 4) || in_empty !== (isz == 0)) begin errors++; $display("FAIL rnd_in_status: got rdy=%b empty=%b expected count %0d", ext_rx_ready, in_empty, isz); end
            checks++; if (out_overflow !== exp_ovf || in_underflow !== exp_unf) begin errors++; $display("FAIL rnd_flags: got %b%b expected %b%b", out_overflow, in_underflow, exp_ovf, exp_unf); end
            ein = (isz > 0) ? in_q[0] : 16'h0;
            checks++; if (cpu_in_data !== ein) begin errors++; $display("FAIL rnd_in_data: got %h expected %h", cpu_in_data, ein); end
            opop = txr && (osz > 0);
            if (opop) begin
                e = exp_q.pop_front();
                checks++; if (ext_tx_data !== e) begin errors++; $display("FAIL rnd_tx_data: got %h expected %h", ext_tx_data, e); end
            end
            if (we && (osz < 4 || opop)) exp_q.push_back(od);
            ovf_evt = we && (osz == 4) && !opop;
            if (re && isz > 0) void'(in_q.pop_front());
            unf_evt = re && (isz == 0);
            if (rxv && isz < 4) in_q.push_back(rxd);
            exp_ovf = ovf_evt ? 1'b1 : (clr ? 1'b0 : exp_ovf);
            exp_unf = unf_evt ? 1'b1 : (clr ? 1'b0 : exp_unf);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        exp_q.delete();
        in_q.delete();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        idle();
        checks++; if (ext_tx_valid !== 1'b1 || in_empty !== 1'b0) begin errors++; $display("FAIL rm_filled: got v=%b empty=%b expected 1 0", ext_tx_valid, in_empty); end
        // Handshake in flight while reset arrives between edges.
        ext_tx_ready = 1'b1;
        ext_rx_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++; if (ext_tx_valid !== 1'b0 || in_empty !== 1'b1 || ext_rx_ready !== 1'b1) begin errors++; $display("FAIL rm_async: got v=%b empty=%b rdy=%b expected 0 1 1", ext_tx_valid, in_empty, ext_rx_ready); end
        checks++; if (out_full !== 1'b0 || cpu_in_data !== 16'h0) begin errors++; $display("FAIL rm_async2: got full=%b data=%h expected 0 0000", out_full, cpu_in_data); end
        idle();
        reset = 1'b0;
        idle();
        checks++; if (ext_tx_valid !== 1'b0 || in_empty !== 1'b1) begin errors++; $display("FAIL rm_after: got v=%b empty=%b expected 0 1", ext_tx_valid, in_empty); end
    endtask

    initial begin
        test_reset();
        test_out_basic();
        test_out_overflow();
        test_full_push_pop();
        test_in_basic();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
